disp_msg_ctrl: RTL and testbench

- Upstream feeder for the 4-digit seven-segment decoder. Turns calculator-core events into the decoder's write interface.
- Events handled: operator prompt, operand prompt, signed result, error.
- Converts signed results to sign/magnitude, holds the ERR message for a programmable time, then restores the proper screen.
- Sits between the calculator control FSM and the display decoder. Runs on the same clock.

---
 rtl/disp_pkg.sv | 24 ++
 rtl/disp_hold_timer.sv | 16 +
 rtl/disp_msg_ctrl.sv | 85 ++++++++
 tb/tb_disp_msg_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: message codes, state encoding and number helpers shared with the display decoder
package disp_pkg;
  localparam logic [1:0] MSG_NUM = 2'b00;
  localparam logic [1:0] MSG_OP = 2'b01;
  localparam logic [1:0] MSG_VAL = 2'b10;
  localparam logic [1:0] MSG_ERR = 2'b11;
  localparam logic [1:0] DP_NONE = 2'b00;
  // state codes equal the message codes so msg is the state register itself
  localparam logic [1:0] S_NUM = MSG_NUM;
  localparam logic [1:0] S_OP = MSG_OP;
  localparam logic [1:0] S_VAL = MSG_VAL;
  localparam logic [1:0] S_ERR = MSG_ERR;
  localparam logic [8:0] RES_MIN = 9'h100;
  typedef struct packed {
    logic [7:0] bin;
    logic sgn;
    logic [1:0] dp;
  } num_t;
  function automatic num_t to_num(input logic [8:0] r, input logic [1:0] dp);
    logic [7:0] m;
    m = r[8] ? 8'(-r) : r[7:0];
    return '{bin: m, sgn: r[8], dp: dp};
  endfunction
endpackage

// File: rtl/disp_hold_timer.sv
// disp_hold_timer: loadable down-counter that stops at zero; done while it reads zero
module disp_hold_timer #(
  parameter int HOLD = 50000000,
  parameter int TW = $clog2(HOLD)
) (
  input logic clk,
  input logic rst,
  input logic load,
  output logic done
);
  logic [TW-1:0] cnt;
  assign done = cnt == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= load ? TW'(HOLD - 1) : done ? cnt : cnt - TW'(1);
endmodule

// File: rtl/disp_msg_ctrl.sv
// disp_msg_ctrl: turns calculator events into registered write strobes for the 7-seg decoder
module disp_msg_ctrl
  import disp_pkg::*;
#(
  parameter int ERR_HOLD = 50000000,
  parameter int TW = $clog2(ERR_HOLD)
) (
  input logic clk,
  input logic rst,
  input logic prompt_op,
  input logic prompt_val,
  input logic res_valid,
  input logic [8:0] res,
  input logic [1:0] res_dp,
  input logic err,
  output logic [1:0] msg,
  output logic display_sel,
  output logic wr_enable,
  output logic [7:0] bin,
  output logic sgn,
  output logic [1:0] dot,
  output logic err_active
);
  logic [1:0] state, n_state;
  num_t last, n_last, shown, n_shown;
  logic op_q, op_q2, val_q, val_q2;
  logic bad, load, done, n_wr;
  disp_hold_timer #(.HOLD(ERR_HOLD), .TW(TW)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(load),
    .done(done)
  );
  always_comb begin
    bad = res_valid & (res == RES_MIN);
    n_last = (res_valid & ~bad) ? to_num(res, res_dp) : last;
    n_state = state;
    n_shown = shown;
    n_wr = 1'b0;
    load = 1'b0;
    if (err | bad) begin
      n_state = S_ERR;
      load = 1'b1;
      n_wr = 1'b1;
    end else if (state == S_ERR) begin
      // prompt edges seen while ERR is held are dropped; only the levels pick the exit screen
      if (done) begin
        n_state = op_q ? S_OP : val_q ? S_VAL : S_NUM;
        n_shown = (op_q | val_q) ? shown : n_last;
        n_wr = 1'b1;
      end
    end else if (res_valid) begin
      n_state = S_NUM;
      n_shown = n_last;
      n_wr = 1'b1;
    end else if (op_q & ~op_q2) begin
      n_state = S_OP;
      n_wr = state != S_OP;
    end else if (val_q & ~val_q2) begin
      n_state = S_VAL;
      n_wr = state != S_VAL;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_NUM;
      last <= '{bin: 8'd0, sgn: 1'b0, dp: DP_NONE};
      shown <= '{bin: 8'd0, sgn: 1'b0, dp: DP_NONE};
      wr_enable <= 1'b0;
      err_active <= 1'b0;
      {op_q, op_q2, val_q, val_q2} <= '0;
    end else begin
      state <= n_state;
      last <= n_last;
      shown <= n_shown;
      wr_enable <= n_wr;
      err_active <= n_state == S_ERR;
      {op_q, op_q2, val_q, val_q2} <= {prompt_op, op_q, prompt_val, val_q};
    end
  assign msg = state;
  assign display_sel = wr_enable;
  assign bin = shown.bin;
  assign sgn = shown.sgn;
  assign dot = shown.dp;
endmodule

// File: tb/tb_disp_msg_ctrl.sv
// tb_disp_msg_ctrl: directed checks of disp_msg_ctrl with ERR_HOLD=8
module tb_disp_msg_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic prompt_op = 1'b0, prompt_val = 1'b0, res_valid = 1'b0, err = 1'b0;
  logic [8:0] res = '0;
  logic [1:0] res_dp = '0;
  logic [1:0] msg, dot;
  logic display_sel, wr_enable, sgn, err_active;
  logic [7:0] bin;
  int n_chk = 0, n_pass = 0, n;
  logic any_out;
  disp_msg_ctrl #(.ERR_HOLD(8)) dut (
    .clk(clk), .rst(rst), .prompt_op(prompt_op), .prompt_val(prompt_val),
    .res_valid(res_valid), .res(res), .res_dp(res_dp), .err(err),
    .msg(msg), .display_sel(display_sel), .wr_enable(wr_enable),
    .bin(bin), .sgn(sgn), .dot(dot), .err_active(err_active)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_strobe(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!wr_enable && cyc < 30);
  endtask
  task automatic send_res(input logic [8:0] r, input logic [1:0] dp);
    res_valid = 1'b1;
    res = r;
    res_dp = dp;
    tick();
    res_valid = 1'b0;
  endtask
  task automatic pulse_err();
    err = 1'b1;
    tick();
    err = 1'b0;
  endtask
  initial begin
    tick();
    check("reset_outs", {msg, bin, sgn, dot, wr_enable, display_sel, err_active}, 0);
    rst = 1'b0;
    any_out = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      any_out |= |{msg, bin, sgn, dot, wr_enable, display_sel, err_active};
    end
    check("idle_20", any_out, 0);
    send_res(9'h1DB, 2'd2);
    check("neg37", {msg, bin, sgn, dot, wr_enable, display_sel}, {2'b00, 8'd37, 1'b1, 2'd2, 1'b1, 1'b1});
    tick();
    check("neg37_once", wr_enable, 0);
    prompt_op = 1'b1;
    tick();
    check("op_lat1", {msg, wr_enable}, {2'b00, 1'b0});
    tick();
    check("op_entry", {msg, bin, wr_enable}, {2'b01, 8'd37, 1'b1});
    tick();
    tick();
    check("op_held", {msg, wr_enable}, {2'b01, 1'b0});
    prompt_op = 1'b0;
    tick();
    prompt_val = 1'b1;
    tick();
    check("val_lat1", msg, 2'b01);
    prompt_val = 1'b0;
    tick();
    check("val_entry", {msg, bin, wr_enable}, {2'b10, 8'd37, 1'b1});
    tick();
    tick();
    pulse_err();
    check("err_entry", {msg, err_active, wr_enable, display_sel}, {2'b11, 1'b1, 1'b1, 1'b1});
    wait_strobe(n);
    check("err_len", n, 8);
    check("err_exit", {msg, bin, sgn, dot, err_active}, {2'b00, 8'd37, 1'b1, 2'd2, 1'b0});
    pulse_err();
    tick();
    tick();
    send_res(9'd100, 2'd0);
    check("res_in_err", {msg, wr_enable, bin}, {2'b11, 1'b0, 8'd37});
    tick();
    pulse_err();
    check("retrigger", {msg, wr_enable, err_active}, {2'b11, 1'b1, 1'b1});
    wait_strobe(n);
    check("retrig_len", n, 8);
    check("exit_100", {msg, bin, sgn, dot}, {2'b00, 8'd100, 1'b0, 2'd0});
    send_res(9'h100, 2'd1);
    check("min_is_err", {msg, err_active, wr_enable}, {2'b11, 1'b1, 1'b1});
    wait_strobe(n);
    check("min_len", n, 8);
    check("min_shadow", {msg, bin, sgn, dot}, {2'b00, 8'd100, 1'b0, 2'd0});
    err = 1'b1;
    prompt_op = 1'b1;
    send_res(9'd5, 2'd1);
    err = 1'b0;
    check("err_res_same", {msg, bin}, {2'b11, 8'd100});
    wait_strobe(n);
    check("op_level_len", n, 8);
    check("exit_to_op", {msg, bin, err_active}, {2'b01, 8'd100, 1'b0});
    tick();
    check("no_late_op", wr_enable, 0);
    prompt_op = 1'b0;
    tick();
    tick();
    pulse_err();
    wait_strobe(n);
    check("shadow5", {msg, bin, sgn, dot}, {2'b00, 8'd5, 1'b0, 2'd1});
    send_res(9'h1FF, 2'd3);
    check("neg1", {bin, sgn, dot}, {8'd1, 1'b1, 2'd3});
    send_res(9'd255, 2'd0);
    check("pos255", {bin, sgn}, {8'd255, 1'b0});
    send_res(9'd0, 2'd0);
    check("zero_sgn", {bin, sgn, wr_enable}, {8'd0, 1'b0, 1'b1});
    prompt_op = 1'b1;
    prompt_val = 1'b1;
    tick();
    tick();
    check("op_wins", msg, 2'b01);
    prompt_op = 1'b0;
    prompt_val = 1'b0;
    send_res(9'h1D6, 2'd2);
    pulse_err();
    tick();
    tick();
    #2 rst = 1'b1;
    #1 check("async_rst", {msg, bin, sgn, dot, wr_enable, err_active}, 0);
    tick();
    rst = 1'b0;
    pulse_err();
    wait_strobe(n);
    check("shadow_lost", {msg, bin, sgn, dot}, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
